// File: rtl/lcd_pkg.sv
// Shared constants for the taximeter LCD text path: ASCII codes, row literals,
// BCD engine widths and the formatter FSM encoding.
package lcd_pkg;

    localparam int ROW_W      = 128;
    localparam int ROW_CHARS  = 16;
    localparam int BIN_W      = 16;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    localparam logic [39:0] STR_FARE = "FARE:";
    localparam logic [31:0] STR_CNY  = " CNY";
    localparam logic [15:0] STR_D    = "D:";
    localparam logic [23:0] STR_T    = " T:";

    localparam logic [ROW_W-1:0] ROW_BLANK = {ROW_CHARS{ASCII_SP}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_STORE  = 2'd2,
        ST_FORMAT = 2'd3
    } fmt_state_e;

    function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
        return blank ? ASCII_SP : (ASCII_0 + {4'b0000, d});
    endfunction

endpackage

// File: rtl/bin2bcd16_serial.sv
// Serial shift-add-3 converter: 16-bit binary to 5-digit BCD in 16 cycles.
// start loads the operand; done is high during the final shift cycle.
module bin2bcd16_serial
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] din,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic             active_q, active_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] adj;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
        sr_q  <= sr_d;
        bcd_q <= bcd_d;
    end

    always_comb begin
        adj      = bcd_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        // Correct every digit that would overflow past 9 once doubled.
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            sr_d     = din;
            bcd_d    = '0;
        end else if (active_q) begin
            bcd_d = {adj[BCD_W-2:0], sr_q[BIN_W-1]};
            sr_d  = {sr_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15)
                active_d = 1'b0;
        end
    end

    assign done = active_q && (cnt_q == 4'd15);
    assign bcd  = bcd_q;

endmodule

// File: rtl/lcd_text_formatter.sv
// Periodically samples fare/distance/wait and renders two 16-char ASCII rows.
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zeros with spaces.
module lcd_text_formatter
    import lcd_pkg::*;
#(
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int CNT_W          = 23
) (
    input  logic             CLK,
    input  logic             BTN_TRCK,
    input  logic [15:0]      FARE,
    input  logic [15:0]      DIST,
    input  logic [15:0]      WAIT_S,
    output logic [ROW_W-1:0] row_1,
    output logic [ROW_W-1:0] row_2,
    output logic             ROW_VALID,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(REFRESH_CYCLES - 1);

    fmt_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      fare_q, fare_d, dist_q, dist_d, wait_q, wait_d;
    logic [BCD_W-1:0] fare_bcd_q, fare_bcd_d, dist_bcd_q, dist_bcd_d, wait_bcd_q, wait_bcd_d;
    logic [ROW_W-1:0] row_1_q, row_1_d, row_2_q, row_2_d;
    logic             row_valid_q, row_valid_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic             conv_start, conv_done;
    logic [15:0]      conv_din;
    logic [BCD_W-1:0] conv_bcd;
    logic [1:0]       fare_blk;
    logic [2:0]       dist_blk;
    logic [3:0]       wait_blk;

    assign tick = (cnt_q == TICK_AT);

    // The engine is loaded on the edge that enters CONV, so all 16 CONV cycles shift.
    assign conv_start = ((state_q == ST_IDLE) && tick) ||
                        ((state_q == ST_STORE) && (idx_q != 2'd2));

    always_comb begin
        case (idx_d)
            2'd0:    conv_din = fare_d;
            2'd1:    conv_din = dist_d;
            default: conv_din = wait_d;
        endcase
    end

    bin2bcd16_serial u_bcd (
        .clk   (CLK),
        .rst   (BTN_TRCK),
        .start (conv_start),
        .din   (conv_din),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge CLK) begin
        if (BTN_TRCK) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            row_1_q     <= ROW_BLANK;
            row_2_q     <= ROW_BLANK;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            row_1_q     <= row_1_d;
            row_2_q     <= row_2_d;
            row_valid_q <= row_valid_d;
            busy_q      <= busy_d;
        end
        fare_q     <= fare_d;
        dist_q     <= dist_d;
        wait_q     <= wait_d;
        fare_bcd_q <= fare_bcd_d;
        dist_bcd_q <= dist_bcd_d;
        wait_bcd_q <= wait_bcd_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick) state_d = ST_CONV;
            ST_CONV:   if (conv_done) state_d = ST_STORE;
            ST_STORE:  state_d = (idx_q == 2'd2) ? ST_FORMAT : ST_CONV;
            ST_FORMAT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        fare_blk[1] = (fare_bcd_q[19:16] == 4'd0);
        fare_blk[0] = fare_blk[1] && (fare_bcd_q[15:12] == 4'd0);
        dist_blk[2] = (dist_bcd_q[19:16] == 4'd0);
        dist_blk[1] = dist_blk[2] && (dist_bcd_q[15:12] == 4'd0);
        dist_blk[0] = dist_blk[1] && (dist_bcd_q[11:8] == 4'd0);
        wait_blk[3] = (wait_bcd_q[19:16] == 4'd0);
        wait_blk[2] = wait_blk[3] && (wait_bcd_q[15:12] == 4'd0);
        wait_blk[1] = wait_blk[2] && (wait_bcd_q[11:8] == 4'd0);
        wait_blk[0] = wait_blk[1] && (wait_bcd_q[7:4] == 4'd0);
`else
        fare_blk = '0;
        dist_blk = '0;
        wait_blk = '0;
`endif
    end

    always_comb begin
        cnt_d       = (cnt_q == TICK_AT) ? '0 : cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        fare_d      = fare_q;
        dist_d      = dist_q;
        wait_d      = wait_q;
        fare_bcd_d  = fare_bcd_q;
        dist_bcd_d  = dist_bcd_q;
        wait_bcd_d  = wait_bcd_q;
        row_1_d     = row_1_q;
        row_2_d     = row_2_q;
        row_valid_d = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    fare_d = FARE;
                    dist_d = DIST;
                    wait_d = WAIT_S;
                    idx_d  = 2'd0;
                    busy_d = 1'b1;
                end
            end
            ST_STORE: begin
                case (idx_q)
                    2'd0:    fare_bcd_d = conv_bcd;
                    2'd1:    dist_bcd_d = conv_bcd;
                    default: wait_bcd_d = conv_bcd;
                endcase
                if (idx_q != 2'd2)
                    idx_d = idx_q + 2'd1;
            end
            ST_FORMAT: begin
                row_1_d = {STR_FARE, ASCII_SP,
                           digit_char(fare_bcd_q[19:16], fare_blk[1]),
                           digit_char(fare_bcd_q[15:12], fare_blk[0]),
                           digit_char(fare_bcd_q[11:8],  1'b0), ASCII_DOT,
                           digit_char(fare_bcd_q[7:4],   1'b0),
                           digit_char(fare_bcd_q[3:0],   1'b0), STR_CNY};
                row_2_d = {STR_D,
                           digit_char(dist_bcd_q[19:16], dist_blk[2]),
                           digit_char(dist_bcd_q[15:12], dist_blk[1]),
                           digit_char(dist_bcd_q[11:8],  dist_blk[0]),
                           digit_char(dist_bcd_q[7:4],   1'b0), ASCII_DOT,
                           digit_char(dist_bcd_q[3:0],   1'b0), STR_T,
                           digit_char(wait_bcd_q[19:16], wait_blk[3]),
                           digit_char(wait_bcd_q[15:12], wait_blk[2]),
                           digit_char(wait_bcd_q[11:8],  wait_blk[1]),
                           digit_char(wait_bcd_q[7:4],   wait_blk[0]),
                           digit_char(wait_bcd_q[3:0],   1'b0)};
                row_valid_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: ;
        endcase
    end

    assign row_1     = row_1_q;
    assign row_2     = row_2_q;
    assign ROW_VALID = row_valid_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Scoreboard bench for lcd_text_formatter: a refresh/decimal reference model
// predicts each frame; a monitor checks rows, ROW_VALID and BUSY every cycle.
module tb_lcd_text_formatter;

    localparam int R   = 40;
    localparam int LAT = 52;
    localparam logic [127:0] BLANKROW = {16{8'h20}};
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         BTN_TRCK;
    logic [15:0]  FARE, DIST, WAIT_S;
    logic [127:0] row_1, row_2;
    logic         ROW_VALID, BUSY;

    lcd_text_formatter #(.REFRESH_CYCLES(R), .CNT_W(23)) dut (
        .CLK       (CLK),
        .BTN_TRCK  (BTN_TRCK),
        .FARE      (FARE),
        .DIST      (DIST),
        .WAIT_S    (WAIT_S),
        .row_1     (row_1),
        .row_2     (row_2),
        .ROW_VALID (ROW_VALID),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] r1;
        logic [127:0] r2;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           nvec = 0;
    int           nfail = 0;
    int           edge_no = 0;
    int           busy_start = -1000;
    int           tcnt = 0;
    bit           started = 1'b0;
    logic [127:0] cur_r1 = BLANKROW;
    logic [127:0] cur_r2 = BLANKROW;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at edge %0d: got %h, want %h", nm, edge_no, act, exp);
        end
    endfunction

    function automatic logic [127:0] put_chr(logic [127:0] r, int pos, logic [7:0] c);
        r[127-8*pos -: 8] = c;
        return r;
    endfunction

    function automatic logic [127:0] put_str(logic [127:0] r, int pos, string s);
        for (int i = 0; i < s.len(); i++) r = put_chr(r, pos + i, s[i]);
        return r;
    endfunction

    // Decimal field of n digits; the last 'keep' digits are never blanked.
    function automatic logic [127:0] put_num(logic [127:0] r, int pos, int v, int n, int keep);
        int p;
        for (int k = 0; k < n; k++) begin
            p = 1;
            for (int j = 0; j < n - 1 - k; j++) p = p * 10;
            if (BLANK && (k < n - keep) && (v / p == 0))
                r = put_chr(r, pos + k, 8'h20);
            else
                r = put_chr(r, pos + k, 8'(8'h30 + (v / p) % 10));
        end
        return r;
    endfunction

    function automatic logic [127:0] model_row1(int f);
        logic [127:0] r;
        r = BLANKROW;
        r = put_str(r, 0, "FARE: ");
        r = put_num(r, 6, f / 100, 3, 1);
        r = put_chr(r, 9, ".");
        r = put_num(r, 10, f % 100, 2, 2);
        r = put_str(r, 12, " CNY");
        return r;
    endfunction

    function automatic logic [127:0] model_row2(int d, int w);
        logic [127:0] r;
        r = BLANKROW;
        r = put_str(r, 0, "D:");
        r = put_num(r, 2, d / 10, 4, 1);
        r = put_chr(r, 6, ".");
        r = put_num(r, 7, d % 10, 1, 1);
        r = put_str(r, 8, " T:");
        r = put_num(r, 11, w, 5, 1);
        return r;
    endfunction

    // Predictor: tracks the refresh schedule and queues the frame each accepted tick yields.
    initial begin : predictor
        bit   tick;
        exp_t e;
        forever begin
            @(posedge CLK);
            edge_no++;
            if (BTN_TRCK) begin
                started    = 1'b1;
                tcnt       = 0;
                sb.delete();
                busy_start = -1000;
                cur_r1     = BLANKROW;
                cur_r2     = BLANKROW;
            end else begin
                tick = (tcnt == R - 1);
                tcnt = tick ? 0 : tcnt + 1;
                if (sb.size() > 0 && sb[0].due == edge_no) begin
                    cur_r1 = sb[0].r1;
                    cur_r2 = sb[0].r2;
                end
                if (started && tick && (edge_no > busy_start + LAT)) begin
                    e.r1  = model_row1(int'(FARE));
                    e.r2  = model_row2(int'(DIST), int'(WAIT_S));
                    e.due = edge_no + LAT;
                    sb.push_back(e);
                    busy_start = edge_no;
                end
            end
        end
    end

    initial begin : monitor
        bit exp_v;
        bit exp_b;
        forever begin
            @(negedge CLK);
            if (started) begin
                exp_v = (sb.size() > 0) && (sb[0].due == edge_no);
                exp_b = (edge_no >= busy_start) && (edge_no <= busy_start + LAT - 1);
                chk("row_valid", {127'd0, ROW_VALID}, {127'd0, exp_v});
                chk("busy", {127'd0, BUSY}, {127'd0, exp_b});
                if (exp_v) void'(sb.pop_front());
                chk("row_1", row_1, cur_r1);
                chk("row_2", row_2, cur_r2);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_busy();
        int k;
        k = 0;
        while (!BUSY && k < 200) begin
            step(1);
            k++;
        end
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'hFFFF;
            2:       return 16'($urandom_range(0, 120));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin : driver
        BTN_TRCK = 1'b1;
        FARE = 16'd0;
        DIST = 16'd0;
        WAIT_S = 16'd0;
        step(3);
        BTN_TRCK = 1'b0;
        FARE = 16'd12345; DIST = 16'd123;   WAIT_S = 16'd75;
        step(140);
        FARE = 16'hFFFF;  DIST = 16'hFFFF;  WAIT_S = 16'hFFFF;
        step(100);
        FARE = 16'd5;     DIST = 16'd0;     WAIT_S = 16'd0;
        step(100);
        FARE = 16'd100;   DIST = 16'd20;    WAIT_S = 16'd9;
        wait_busy();
        step(10);
        FARE = 16'd999;
        step(150);
        wait_busy();
        step(20);
        BTN_TRCK = 1'b1;
        step(1);
        BTN_TRCK = 1'b0;
        step(120);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       FARE   = pick_val();
                    1:       DIST   = pick_val();
                    default: WAIT_S = pick_val();
                endcase
            end
            BTN_TRCK = ($urandom_range(0, 699) == 0);
            step(1);
        end
        BTN_TRCK = 1'b0;
        step(120);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
